// File: rtl/tt_vector_sequencer_if.sv
// Host-side vector port of the sequencer: one stim/expected/mask triple per
// valid/ready handshake.
interface tt_vector_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             vec_valid;
  logic             vec_ready;
  logic [WIDTH-1:0] vec_stim;
  logic [WIDTH-1:0] vec_exp;
  logic [WIDTH-1:0] vec_mask;

  modport master (
    output vec_valid,
    output vec_stim,
    output vec_exp,
    output vec_mask,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  vec_stim,
    input  vec_exp,
    input  vec_mask,
    output vec_ready
  );
endinterface

// File: rtl/tt_vector_sequencer.sv
// Buffers host test vectors, plays them onto the DUT pins one per cycle and
// checks the DUT response LATENCY edges later against a masked expectation.
module tt_vector_sequencer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  tt_vector_sequencer_if.slave     host,
  input  logic                     start,
  output logic [WIDTH-1:0]         dut_in,
  input  logic [WIDTH-1:0]         dut_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         err_count,
  output logic [CNT_W-1:0]         first_err_idx,
  output logic [WIDTH-1:0]         first_err_got,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] stim;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] mask;
  } vec_t;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] idx;
  } slot_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  vec_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] idx;
  slot_t            dl [LATENCY];

  logic             push;
  logic             pop;
  logic             go;
  logic             fin;
  logic             last_pop;
  logic             inflight;
  logic             mismatch;
  logic             busy_nxt;
  logic [LATENCY-1:0] dl_valid;
  logic [LATENCY-1:0] dl_upper;
  logic [LW-1:0]    level_nxt;
  logic [CNT_W-1:0] err_nxt;
  vec_t             rd_vec;
  slot_t            head;

  assign push      = host.vec_valid & host.vec_ready;
  assign go        = (state == IDLE) & start;
  assign pop       = (state == RUN) & (level != '0);
  assign last_pop  = pop & (level == LW'(1));
  assign rd_vec    = mem[rd_ptr];
  assign head      = dl[LATENCY-1];
  assign level_nxt = level + LW'(push) - LW'(pop);
  assign busy_nxt  = go | (busy & ~fin);

  always_comb begin
    dl_valid = '0;
    for (int i = 0; i < int'(LATENCY); i++) dl_valid[i] = dl[i].valid;
  end

  // Anything still in flight behind the slot being compared this edge.
  assign dl_upper = dl_valid << 1;
  assign inflight = |dl_upper;
  assign fin      = (state == DRAIN) & ~inflight;

  assign mismatch = head.valid & (|((dut_out ^ head.exp) & head.mask));
  assign err_nxt  = (mismatch && (err_count != '1)) ? err_count + CNT_W'(1) : err_count;

  // Vector storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{stim: host.vec_stim, exp: host.vec_exp, mask: host.vec_mask};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      idx            <= '0;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_got  <= '0;
      host.vec_ready <= 1'b1;
      for (int i = 0; i < int'(LATENCY); i++) dl[i] <= '0;
    end else begin
      done           <= 1'b0;
      level          <= level_nxt;
      busy           <= busy_nxt;
      host.vec_ready <= ~busy_nxt & (level_nxt != LW'(DEPTH));

      if (push) wr_ptr <= wr_ptr + AW'(1);

      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        dut_in <= rd_vec.stim;
        idx    <= idx + CNT_W'(1);
        dl[0]  <= '{valid: 1'b1, exp: rd_vec.exp, mask: rd_vec.mask, idx: idx};
      end else begin
        dl[0]  <= '0;
      end
      for (int i = 1; i < int'(LATENCY); i++) dl[i] <= dl[i-1];

      // The first mismatch is the one seen while the counter is still zero.
      if (mismatch) begin
        err_count <= err_nxt;
        if (err_count == '0) begin
          first_err_idx <= head.idx;
          first_err_got <= dut_out;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state         <= (level_nxt == '0) ? DRAIN : RUN;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            pass          <= 1'b0;
            idx           <= '0;
          end
        end
        RUN: begin
          if (last_pop) state <= DRAIN;
        end
        DRAIN: begin
          if (fin) begin
            state <= IDLE;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_vector_sequencer.sv
// Randomised scoreboard bench: a default-parameter instance plus a small-counter
// instance for saturation and index wrap.
module tb_tt_vector_sequencer;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned L  = 1;
  localparam int unsigned CW = 16;
  localparam int unsigned SD = 32;
  localparam int unsigned SCW = 4;

  typedef struct packed {
    logic [W-1:0] stim;
    logic [W-1:0] exp;
    logic [W-1:0] mask;
  } tvec_t;

  typedef struct {
    int           n;
    int           err;
    int           fidx;
    logic [W-1:0] fgot;
    bit           pass;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tt_vector_sequencer_if #(.WIDTH(W)) host_if ();
  tt_vector_sequencer_if #(.WIDTH(W)) sat_if ();

  logic          start, busy, done, pass;
  logic [W-1:0]  dut_in, dut_out, first_err_got, key;
  logic [CW-1:0] err_count, first_err_idx;
  logic [4:0]    level;

  logic           s_start, s_busy, s_done, s_pass;
  logic [W-1:0]   s_dut_in, s_dut_out, s_first_err_got, s_key;
  logic [SCW-1:0] s_err_count, s_first_err_idx;
  logic [5:0]     s_level;

  assign dut_out   = dut_in ^ key;
  assign s_dut_out = s_dut_in ^ s_key;

  tt_vector_sequencer #(.WIDTH(W), .DEPTH(D), .LATENCY(L), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .host(host_if.slave), .start(start),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx),
    .first_err_got(first_err_got), .level(level)
  );

  tt_vector_sequencer #(.WIDTH(W), .DEPTH(SD), .LATENCY(L), .CNT_W(SCW)) u_sat (
    .clk(clk), .rst(rst), .host(sat_if.slave), .start(s_start),
    .dut_in(s_dut_in), .dut_out(s_dut_out), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err_count), .first_err_idx(s_first_err_idx),
    .first_err_got(s_first_err_got), .level(s_level)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit aborting = 1'b0;

  tvec_t        mq[$];
  tvec_t        smq[$];
  res_t         res_q[$];
  res_t         sat_q[$];
  logic [W-1:0] drv_q[$];
  int           len_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: what a run of these vectors must report, straight from the rules.
  function automatic res_t model_run(input tvec_t q[$], input logic [W-1:0] k, input int cw);
    res_t         r;
    logic [W-1:0] got;
    bit           seen;
    int           maxc;
    maxc   = (1 << cw) - 1;
    seen   = 1'b0;
    r.n    = q.size();
    r.err  = 0;
    r.fidx = 0;
    r.fgot = '0;
    foreach (q[i]) begin
      got = q[i].stim ^ k;
      if (((got ^ q[i].exp) & q[i].mask) != '0) begin
        if (!seen) begin
          seen   = 1'b1;
          r.fidx = i % (1 << cw);
          r.fgot = got;
        end
        if (r.err < maxc) r.err++;
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  // Result monitor for the main instance.
  logic rb_prev = 1'b0;
  int   e_cyc   = 0;
  always @(negedge clk) begin
    res_t r;
    if (busy && !rb_prev) e_cyc = cyc;
    if (done) begin
      if (res_q.size() == 0) begin
        chk("unexpected_done", res_q.size(), 1);
      end else begin
        r = res_q.pop_front();
        chk("err_count", err_count, r.err);
        chk("first_err_idx", first_err_idx, r.fidx);
        if (!r.pass) chk("first_err_got", first_err_got, r.fgot);
        chk("pass", pass, r.pass);
        chk("busy_at_done", busy, 0);
        chk("ready_at_done", host_if.vec_ready, 1);
        chk("done_latency", cyc - e_cyc, (r.n == 0) ? 1 : r.n + L);
      end
    end
    rb_prev = busy;
  end

  // Result monitor for the small-counter instance.
  always @(negedge clk) begin
    res_t r;
    if (s_done) begin
      if (sat_q.size() == 0) begin
        chk("sat_unexpected_done", sat_q.size(), 1);
      end else begin
        r = sat_q.pop_front();
        chk("sat_err_count", s_err_count, r.err);
        chk("sat_first_err_idx", s_first_err_idx, r.fidx);
        chk("sat_first_err_got", s_first_err_got, r.fgot);
        chk("sat_pass", s_pass, r.pass);
      end
    end
  end

  // Drive monitor: after a run starts, dut_in must step through the stims.
  logic db_prev = 1'b0;
  always begin
    int n;
    @(negedge clk);
    if (!aborting && busy && !db_prev) begin
      if (len_q.size() == 0) begin
        chk("unexpected_run", len_q.size(), 1);
        n = 0;
      end else begin
        n = len_q.pop_front();
      end
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        if (aborting) break;
        chk("dut_in", dut_in, drv_q.pop_front());
      end
    end
    db_prev = busy;
  end

  task automatic push_vec(input tvec_t v);
    bit acc;
    @(negedge clk);
    chk("level", level, mq.size());
    acc = (mq.size() < D);
    chk("vec_ready", host_if.vec_ready, acc);
    host_if.vec_valid = 1'b1;
    host_if.vec_stim  = v.stim;
    host_if.vec_exp   = v.exp;
    host_if.vec_mask  = v.mask;
    @(posedge clk);
    #1 host_if.vec_valid = 1'b0;
    if (acc) mq.push_back(v);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("run_timeout", busy, 0);
  endtask

  task automatic run_seq(input logic [W-1:0] k, input bit with_push, input tvec_t pv, input bit poke);
    res_t r;
    bit   acc;
    @(negedge clk);
    key   = k;
    start = 1'b1;
    if (with_push) begin
      acc = (mq.size() < D);
      chk("vec_ready_start", host_if.vec_ready, acc);
      host_if.vec_valid = 1'b1;
      host_if.vec_stim  = pv.stim;
      host_if.vec_exp   = pv.exp;
      host_if.vec_mask  = pv.mask;
      if (acc) mq.push_back(pv);
    end
    r = model_run(mq, k, CW);
    res_q.push_back(r);
    len_q.push_back(mq.size());
    foreach (mq[i]) drv_q.push_back(mq[i].stim);
    mq.delete();
    @(posedge clk);
    #1 start = 1'b0;
    host_if.vec_valid = 1'b0;
    if (poke) begin
      @(negedge clk);
      chk("busy_after_start", busy, 1);
      chk("ready_while_busy", host_if.vec_ready, 0);
      start = 1'b1;
      host_if.vec_valid = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      host_if.vec_valid = 1'b0;
    end
    wait_idle();
  endtask

  task automatic s_push(input tvec_t v);
    @(negedge clk);
    chk("sat_level", s_level, smq.size());
    sat_if.vec_valid = 1'b1;
    sat_if.vec_stim  = v.stim;
    sat_if.vec_exp   = v.exp;
    sat_if.vec_mask  = v.mask;
    @(posedge clk);
    #1 sat_if.vec_valid = 1'b0;
    smq.push_back(v);
  endtask

  task automatic s_run(input logic [W-1:0] k);
    int t;
    @(negedge clk);
    s_key   = k;
    s_start = 1'b1;
    sat_q.push_back(model_run(smq, k, SCW));
    smq.delete();
    @(posedge clk);
    #1 s_start = 1'b0;
    t = 0;
    while (s_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (s_busy) chk("sat_run_timeout", s_busy, 0);
  endtask

  initial begin
    tvec_t        v;
    logic [W-1:0] k;
    logic [7:0]   pat [4];
    int           n;
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;

    rst = 1'b1; start = 1'b0; key = '0; s_start = 1'b0; s_key = '0;
    host_if.vec_valid = 1'b0; host_if.vec_stim = '0; host_if.vec_exp = '0; host_if.vec_mask = '0;
    sat_if.vec_valid = 1'b0; sat_if.vec_stim = '0; sat_if.vec_exp = '0; sat_if.vec_mask = '0;
    repeat (2) @(negedge clk);
    chk("rst_dut_in", dut_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_first_err_idx", first_err_idx, 0);
    chk("rst_first_err_got", first_err_got, 0);
    chk("rst_level", level, 0);
    chk("rst_vec_ready", host_if.vec_ready, 1);
    chk("rst_sat_ready", sat_if.vec_ready, 1);
    rst = 1'b0;

    // Directed: passing loopback, single mismatch, masked-off mismatch.
    for (int i = 0; i < 4; i++) push_vec('{stim: pat[i], exp: pat[i], mask: 8'hFF});
    run_seq(8'h00, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) push_vec('{stim: pat[i], exp: (i == 2) ? 8'h3F : pat[i], mask: 8'hFF});
    run_seq(8'h00, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) push_vec('{stim: pat[i], exp: (i == 2) ? 8'h3F : pat[i], mask: 8'hC0});
    run_seq(8'h00, 1'b0, '0, 1'b0);

    // Full FIFO, refused 17th push, then an empty run.
    k = 8'($urandom);
    for (int i = 0; i < int'(D) + 1; i++) begin
      v.stim = 8'($urandom); v.exp = (i % 3 == 0) ? 8'($urandom) : v.stim ^ k; v.mask = 8'($urandom);
      push_vec(v);
    end
    @(negedge clk);
    chk("level_full", level, D);
    chk("ready_full", host_if.vec_ready, 0);
    run_seq(k, 1'b0, '0, 1'b0);
    run_seq(8'h00, 1'b0, '0, 1'b0);

    // Push on the start edge, then start/push while busy.
    push_vec('{stim: 8'hA5, exp: 8'hA5, mask: 8'hFF});
    push_vec('{stim: 8'h5A, exp: 8'h00, mask: 8'h0F});
    run_seq(8'h00, 1'b1, '{stim: 8'hC3, exp: 8'hC0, mask: 8'hFF}, 1'b1);
    push_vec('{stim: 8'h01, exp: 8'h01, mask: 8'hFF});
    run_seq(8'h00, 1'b0, '0, 1'b0);

    // Randomised runs.
    for (int r = 0; r < 12; r++) begin
      k = 8'($urandom);
      n = $urandom_range(0, D);
      for (int i = 0; i < n; i++) begin
        v.stim = 8'($urandom);
        case ($urandom_range(0, 3))
          0: begin v.exp = v.stim ^ k; v.mask = 8'($urandom); end
          1: begin v.exp = 8'($urandom); v.mask = 8'hFF; end
          2: begin v.exp = 8'($urandom); v.mask = 8'h00; end
          default: begin v.exp = v.stim ^ k ^ 8'(1 << $urandom_range(0, 7)); v.mask = 8'($urandom); end
        endcase
        push_vec(v);
      end
      run_seq(k, 1'b0, '0, 1'b0);
    end

    // Reset in the middle of a failing run.
    k = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      v.stim = 8'($urandom); v.exp = ~(v.stim ^ k); v.mask = 8'hFF;
      push_vec(v);
    end
    @(negedge clk);
    key = k; start = 1'b1;
    len_q.push_back(mq.size());
    foreach (mq[i]) drv_q.push_back(mq[i].stim);
    mq.delete();
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_before_rst", err_count != '0, 1);
    aborting = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_level", level, 0);
    chk("abort_dut_in", dut_in, 0);
    chk("abort_err_count", err_count, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", host_if.vec_ready, 1);
    drv_q.delete();
    len_q.delete();
    @(negedge clk);
    aborting = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("no_done_after_abort", done, 0);
    end

    // Small counter: saturation, then a first failure past the index wrap.
    for (int i = 0; i < 20; i++) begin
      v.stim = 8'($urandom); v.exp = ~v.stim; v.mask = 8'hFF;
      s_push(v);
    end
    s_run(8'h00);
    k = 8'h96;
    for (int i = 0; i < 20; i++) begin
      v.stim = 8'($urandom); v.exp = (i < 17) ? v.stim ^ k : ~(v.stim ^ k); v.mask = 8'hFF;
      s_push(v);
    end
    s_run(k);

    repeat (3) @(negedge clk);
    chk("results_pending", res_q.size(), 0);
    chk("sat_results_pending", sat_q.size(), 0);
    chk("drives_pending", drv_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
